// File: rtl/cardinal_dmem_if.sv
// Data-memory access bus between the cardinal processor data port and cardinal_dmem.
// Handshake: a request is DmemEn=1 for one cycle with no ready; it is accepted on that edge unless Init_Busy, and a read answers with a one-cycle Rd_Valid pulse.
interface cardinal_dmem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) ();
    logic [0:ADDR_W-1] Mem_Addr;
    logic [0:DATA_W-1] Wr_Data;
    logic              DmemEn;
    logic              DmemWrEn;
    logic [0:DATA_W-1] Rd_Data;
    logic              Rd_Valid;

    modport master (
        output Mem_Addr, Wr_Data, DmemEn, DmemWrEn,
        input  Rd_Data, Rd_Valid
    );

    modport slave (
        input  Mem_Addr, Wr_Data, DmemEn, DmemWrEn,
        output Rd_Data, Rd_Valid
    );
endinterface

// File: rtl/cardinal_dmem.sv
// cardinal data memory: 2^ADDR_W x DATA_W words, registered read, zero-clear after
// every reset, saturating read/write access counters.
module cardinal_dmem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    cardinal_dmem_if.slave    bus,
    output logic              Init_Busy,
    output logic [0:CNT_W-1]  Rd_Cnt,
    output logic [0:CNT_W-1]  Wr_Cnt,
    output logic              Fsm_State
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [0:ADDR_W-1] LAST_PTR = '1;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [0:ADDR_W-1] clr_ptr;

    logic [0:DATA_W-1] mem [0:DEPTH-1];

    logic              mem_we;
    logic [0:ADDR_W-1] mem_waddr;
    logic [0:DATA_W-1] mem_wdata;
    logic              rd_acc;
    logic              wr_acc;

    logic [0:DATA_W-1] rd_data_q;
    logic              rd_valid_q;

    // State register
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_ptr == LAST_PTR) begin
            state_next = IDLE;
        end
    end

    // Output decode: the clear sweep owns the write port, so bus requests are dropped while busy
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_ptr;
        mem_wdata = '0;
        rd_acc    = 1'b0;
        wr_acc    = 1'b0;
        if (state == CLEAR) begin
            mem_we = Reset;
        end else if (Reset && bus.DmemEn) begin
            if (bus.DmemWrEn) begin
                mem_we    = 1'b1;
                mem_waddr = bus.Mem_Addr;
                mem_wdata = bus.Wr_Data;
                wr_acc    = 1'b1;
            end else begin
                rd_acc = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            clr_ptr <= '0;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
        end
    end

    // Storage has no reset; the clear sweep is what zeroes it.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem[bus.Mem_Addr];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Rd_Cnt <= '0;
            Wr_Cnt <= '0;
        end else begin
            if (rd_acc && Rd_Cnt != '1) begin
                Rd_Cnt <= Rd_Cnt + 1'b1;
            end
            if (wr_acc && Wr_Cnt != '1) begin
                Wr_Cnt <= Wr_Cnt + 1'b1;
            end
        end
    end

    assign bus.Rd_Data  = rd_data_q;
    assign bus.Rd_Valid = rd_valid_q;
    assign Init_Busy    = (state == CLEAR);
    assign Fsm_State    = state;

endmodule
